// File: rtl/window_gen3_if.sv
// Pixel-in / window-out stream bundle for window_gen3.
// WINDOW_GEN3_FRAME_CHECK_EN adds i_last / o_frame_err.
interface window_gen3_if #(parameter int DATA_WIDTH = 4);
  logic                             i_valid;
  logic                             o_ready;
  logic [DATA_WIDTH-1:0]            i_pixel;
  logic [0:2][0:2][DATA_WIDTH-1:0]  o_window;
  logic                             o_valid;
  logic                             i_ready;
  logic                             o_frame_done;
`ifdef WINDOW_GEN3_FRAME_CHECK_EN
  logic                             i_last;
  logic                             o_frame_err;

  modport master (output i_valid, i_pixel, i_ready, i_last,
                  input  o_ready, o_window, o_valid, o_frame_done, o_frame_err);
  modport slave  (input  i_valid, i_pixel, i_ready, i_last,
                  output o_ready, o_window, o_valid, o_frame_done, o_frame_err);
`else
  modport master (output i_valid, i_pixel, i_ready,
                  input  o_ready, o_window, o_valid, o_frame_done);
  modport slave  (input  i_valid, i_pixel, i_ready,
                  output o_ready, o_window, o_valid, o_frame_done);
`endif
endinterface

// File: rtl/window_gen3.sv
// Streaming 3x3 sliding-window generator over two line buffers, raster-order input.
// Optional WINDOW_GEN3_FRAME_CHECK_EN: i_last frame-boundary check with resync.
module window_gen3 #(
  parameter int DATA_WIDTH = 4,
  parameter int IMG_WIDTH  = 8,
  parameter int IMG_HEIGHT = 8
) (
  input logic           i_clk,
  input logic           i_rst,
  window_gen3_if.slave  bus
);
  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);

  typedef logic [DATA_WIDTH-1:0] pix_t;

  pix_t            lb0 [IMG_WIDTH];
  pix_t            lb1 [IMG_WIDTH];
  pix_t [0:2]      tap;
  logic [CW-1:0]   col;
  logic [RW-1:0]   row;
  logic            accept, at_last, row_end, interior, wrap_frame;

  assign bus.o_ready = !bus.o_valid || bus.i_ready;
  assign accept      = bus.i_valid && bus.o_ready;
  assign row_end     = (col == CW'(IMG_WIDTH-1));
  assign at_last     = row_end && (row == RW'(IMG_HEIGHT-1));
  assign interior    = (row >= RW'(2)) && (col >= CW'(2));

  // New right-hand column: oldest row from lb1, middle from lb0, newest is the incoming pixel
  assign tap[0] = lb1[col];
  assign tap[1] = lb0[col];
  assign tap[2] = bus.i_pixel;

`ifdef WINDOW_GEN3_FRAME_CHECK_EN
  assign wrap_frame = at_last || bus.i_last;
`else
  assign wrap_frame = at_last;
`endif

  // Line buffers carry no reset; row/col gating keeps stale entries out of valid windows
  always_ff @(posedge i_clk) begin
    if (accept) begin
      lb1[col] <= lb0[col];
      lb0[col] <= bus.i_pixel;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      bus.o_valid      <= 1'b0;
      bus.o_frame_done <= 1'b0;
      bus.o_window     <= '0;
      row              <= '0;
      col              <= '0;
`ifdef WINDOW_GEN3_FRAME_CHECK_EN
      bus.o_frame_err  <= 1'b0;
`endif
    end else begin
      bus.o_frame_done <= accept && at_last;
`ifdef WINDOW_GEN3_FRAME_CHECK_EN
      bus.o_frame_err  <= accept && (bus.i_last != at_last);
`endif
      if (accept) begin
        for (int r = 0; r < 3; r++) begin
          bus.o_window[r][0] <= bus.o_window[r][1];
          bus.o_window[r][1] <= bus.o_window[r][2];
          bus.o_window[r][2] <= tap[r];
        end
        bus.o_valid <= interior;
        if (wrap_frame) begin
          row <= '0;
          col <= '0;
        end else if (row_end) begin
          col <= '0;
          row <= row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end else if (bus.i_ready) begin
        bus.o_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_window_gen3.sv
// Directed table-driven bench for window_gen3 on a 4x4 frame.
// Build with WINDOW_GEN3_FRAME_CHECK_EN to also cover the i_last check.
module tb_window_gen3;
  localparam int DW = 4;
  localparam int W  = 4;
  localparam int H  = 4;

  typedef logic [0:2][0:2][DW-1:0] win_t;

  typedef struct {
    logic          v;
    logic          r;
    logic [DW-1:0] p;
    logic          l;
    logic          ev;
    int            tl;
    int            sgn;
    logic          ed;
    logic          erdy;
    logic          eerr;
  } vec_t;

  logic i_clk = 1'b0;
  logic i_rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  vec_t tbl[$];

  always #5 i_clk = ~i_clk;

  window_gen3_if #(.DATA_WIDTH(DW)) bus ();

  window_gen3 #(.DATA_WIDTH(DW), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus.slave)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, req);
    end
  endtask

  // Window whose top-left holds tl; neighbours step by sgn per column and 4*sgn per row
  function automatic win_t mkwin(input int tl, input int sgn);
    win_t w;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        w[i][j] = DW'(tl + sgn * (4 * i + j));
    return w;
  endfunction

  function automatic void add(input logic v, input logic r, input int p, input logic l,
                              input logic ev, input int tl, input int sgn,
                              input logic ed, input logic erdy, input logic eerr);
    vec_t e;
    e.v = v; e.r = r; e.p = DW'(p); e.l = l; e.ev = ev; e.tl = tl; e.sgn = sgn;
    e.ed = ed; e.erdy = erdy; e.eerr = eerr;
    tbl.push_back(e);
  endfunction

  // One full frame of pixels base+sgn*p; optional idle cycles between pixels,
  // a 3-cycle downstream stall before pixel stall_at, and a trailing idle cycle
  function automatic void push_frame(input int base, input int sgn, input bit toggle,
                                     input int stall_at, input bit idle_end);
    for (int p = 0; p < 16; p++) begin
      if (p == stall_at)
        repeat (3) add(1, 0, base + sgn * p, 0, 1, base + sgn * (p - 11), sgn, 0, 0, 0);
      add(1, 1, base + sgn * p, p == 15, (p / 4 >= 2) && (p % 4 >= 2),
          base + sgn * (p - 10), sgn, p == 15, 1, 0);
      if (toggle) add(0, 1, p + 7, 0, 0, 0, 1, 0, 1, 0);
    end
    if (idle_end) add(0, 1, 0, 0, 0, 0, 1, 0, 1, 0);
  endfunction

  // Hand-written expectations for the basic 0..15 frame
  function automatic void build_sc1();
    for (int p = 0; p < 10; p++) add(1, 1, p, 0, 0, 0, 1, 0, 1, 0);
    add(1, 1, 10, 0, 1, 0, 1, 0, 1, 0);
    add(1, 1, 11, 0, 1, 1, 1, 0, 1, 0);
    add(1, 1, 12, 0, 0, 0, 1, 0, 1, 0);
    add(1, 1, 13, 0, 0, 0, 1, 0, 1, 0);
    add(1, 1, 14, 0, 1, 4, 1, 0, 1, 0);
    add(1, 1, 15, 1, 1, 5, 1, 1, 1, 0);
    add(0, 1, 0,  0, 0, 0, 1, 0, 1, 0);
  endfunction

  task automatic apply(input vec_t e, input int idx);
    bus.i_valid = e.v;
    bus.i_ready = e.r;
    bus.i_pixel = e.p;
`ifdef WINDOW_GEN3_FRAME_CHECK_EN
    bus.i_last  = e.l;
`endif
    #1;
    chk($sformatf("o_ready[%0d]", idx), 64'(bus.o_ready), 64'(e.erdy));
    @(posedge i_clk);
    #1;
    chk($sformatf("o_valid[%0d]", idx), 64'(bus.o_valid), 64'(e.ev));
    chk($sformatf("o_frame_done[%0d]", idx), 64'(bus.o_frame_done), 64'(e.ed));
    if (e.ev)
      chk($sformatf("o_window[%0d]", idx), 64'(bus.o_window), 64'(mkwin(e.tl, e.sgn)));
`ifdef WINDOW_GEN3_FRAME_CHECK_EN
    chk($sformatf("o_frame_err[%0d]", idx), 64'(bus.o_frame_err), 64'(e.eerr));
`endif
  endtask

  task automatic run_tbl();
    foreach (tbl[i]) apply(tbl[i], i);
    tbl.delete();
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " o_valid"},      64'(bus.o_valid),      64'(0));
    chk({tag, " o_window"},     64'(bus.o_window),     64'(0));
    chk({tag, " o_frame_done"}, 64'(bus.o_frame_done), 64'(0));
    chk({tag, " o_ready"},      64'(bus.o_ready),      64'(1));
  endtask

  initial begin
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b1;
    bus.i_pixel = '0;
`ifdef WINDOW_GEN3_FRAME_CHECK_EN
    bus.i_last  = 1'b0;
`endif
    #3;
    chk_reset("reset");
    @(negedge i_clk) i_rst = 1'b0;
    @(posedge i_clk);
    #1;

    // Basic frame, full throughput
    build_sc1();
    run_tbl();

    // Downstream stall on the first window
    push_frame(0, 1, 0, 11, 1);
    run_tbl();

    // Two back-to-back frames, second one descending
    push_frame(0, 1, 0, -1, 0);
    push_frame(15, -1, 0, -1, 1);
    run_tbl();

    // Input valid toggling every cycle
    push_frame(0, 1, 1, -1, 1);
    run_tbl();

    // Reset mid-frame after pixel 9, then a clean frame
    for (int p = 0; p < 10; p++) add(1, 1, p, 0, 0, 0, 1, 0, 1, 0);
    run_tbl();
    bus.i_valid = 1'b0;
    i_rst = 1'b1;
    #1;
    chk_reset("midreset");
    @(negedge i_clk) i_rst = 1'b0;
    @(posedge i_clk);
    #1;
    build_sc1();
    run_tbl();

`ifdef WINDOW_GEN3_FRAME_CHECK_EN
    // Early i_last on pixel 9: error pulse, no done, resync to (0,0)
    for (int p = 0; p < 10; p++) add(1, 1, p, p == 9, 0, 0, 1, 0, 1, p == 9);
    push_frame(0, 1, 0, -1, 1);
    run_tbl();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/window_gen3.md
Name: window_gen3

Overview:
- Streaming 3x3 sliding-window generator that sits directly upstream of the 3x3 convolution stage.
- Accepts one pixel per cycle in raster order (row-major) over a valid/ready handshake.
- Keeps the two previous image rows in internal line buffers.
- Emits a registered 3x3 window, which feeds the convolution data input, for every fully-interior position: (IMG_HEIGHT-2)*(IMG_WIDTH-2) windows per frame.

Parameters:
- DATA_WIDTH, 4, pixel width; matches the convolution stage's data width.
- IMG_WIDTH, 8, pixels per row; must be >= 3.
- IMG_HEIGHT, 8, rows per frame; must be >= 3.

Ports:
- i_clk  in  1  clock; all logic on rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_valid  in  1  upstream pixel valid.
- o_ready  out  1  block can accept a pixel this cycle.
- i_pixel  in  DATA_WIDTH  pixel value.
- o_window  out  DATA_WIDTH x [0:2][0:2]  window; [r][c], r=0 is the oldest row, c=0 is the leftmost column.
- o_valid  out  1  o_window holds a valid window.
- i_ready  in  1  downstream accepts the window.
- o_frame_done  out  1  one-cycle pulse after the last pixel of a frame is accepted.

Behaviour:
- Reset (async assert, synchronous deassert handled by the system): o_valid=0, o_frame_done=0, all o_window entries=0, row and col counters=0, o_ready=1.
  - Line-buffer storage is not reset; stale data is never emitted because of the row/col gating below.
- o_ready = !o_valid || i_ready (combinational). An accept occurs when i_valid && o_ready.
- On accept at position (row, col):
  - Shift o_window left per row: [r][0]<=[r][1], [r][1]<=[r][2].
  - [0][2]<=lb1[col], [1][2]<=lb0[col], [2][2]<=i_pixel.
  - lb1[col]<=lb0[col], lb0[col]<=i_pixel.
  - col increments; at IMG_WIDTH-1 it wraps to 0 and row increments. At (IMG_HEIGHT-1, IMG_WIDTH-1) both wrap to 0.
- Output valid gating:
  - Next o_valid=1 iff an accept occurs with row>=2 && col>=2.
  - Otherwise o_valid clears when i_ready=1, and holds when i_ready=0.
- Window contents and latency: the window for pixel (row,col) covers rows row-2..row and cols col-2..col. It appears on o_window/o_valid one cycle after that pixel's accept.
- Stall: while o_valid && !i_ready, o_window and o_valid are held stable, o_ready=0, no pixel is accepted, and counters and line buffers are frozen.
- Simultaneous consume and accept (o_valid && i_ready && i_valid) is a legal full-throughput case: the next window (or o_valid=0) is loaded in the same edge.
- o_frame_done=1 for exactly the cycle after the accept of pixel (IMG_HEIGHT-1, IMG_WIDTH-1). This coincides with o_valid for the final window.
- Back-to-back frames need no idle cycles. Rows 0-1 and cols 0-1 of the new frame produce no windows.
- i_valid without an accept has no effect. i_pixel is ignored when not accepted.
- Reset mid-frame discards the partial frame. The first pixel after reset is treated as (0,0).

Optional Feature:
- Macro: WINDOW_GEN3_FRAME_CHECK_EN.
- Defined:
  - Adds input i_last (1 bit, qualified by accept) and output o_frame_err (1-cycle pulse, reset 0).
  - o_frame_err pulses the cycle after an accept where i_last disagrees with the position being (IMG_HEIGHT-1, IMG_WIDTH-1).
  - If i_last=1 early, counters resync to (0,0) after that pixel and o_frame_done does not pulse.
  - A missing i_last at the final position only flags an error; the counters wrap normally.
- Undefined: neither port exists; frame position comes from the counters alone.

Test Plan:
- IMG_WIDTH=IMG_HEIGHT=4, DATA_WIDTH=4, pixels 0..15, i_valid and i_ready held 1:
  - Exactly 4 windows.
  - First window {0,1,2; 4,5,6; 8,9,10} is valid the cycle after pixel 10 is accepted.
  - Last window {5,6,7; 9,10,11; 13,14,15}.
  - o_frame_done pulses with the last window.
- Same frame with i_ready=0 for 3 cycles while the first window is valid:
  - o_window holds {0,1,2;4,5,6;8,9,10} and o_ready=0.
  - Pixel 11 is accepted only after i_ready returns to 1.
  - The window sequence is unchanged.
- Two consecutive 4x4 frames (pixels 0..15, then 15..0) with no gap:
  - 8 windows total.
  - The second frame's first window is {15,14,13; 11,10,9; 7,6,5}.
  - No window is emitted for that frame's rows 0-1.
- Assert i_rst after pixel 9, then stream pixels 0..15:
  - o_valid and o_window are 0 immediately on assert.
  - The output matches scenario 1 exactly.
- i_valid toggled 1/0 every cycle:
  - Same 4 windows and values as scenario 1.
  - Each window appears one cycle after the accept of its corner pixel.
- With WINDOW_GEN3_FRAME_CHECK_EN, i_last=1 on pixel 9:
  - o_frame_err pulses once.
  - The next pixel is treated as (0,0).
  - o_frame_done does not pulse.
